// File: rtl/uart_cmd_parser.sv
// Frame-level command parser between the UART RX byte stream and the rover command port.
// Frames are SOF, ID, LEN, PAYLOAD[LEN], CHK; each frame is answered with ACK or NAK on the TX port.
module uart_cmd_parser #(
    parameter int         MAX_PAYLOAD  = 4,
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter logic [7:0] ACK_BYTE     = 8'h06,
    parameter logic [7:0] NAK_BYTE     = 8'h15,
    parameter int         TIMEOUT_CLKS = 480000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               rx_valid,
    input  logic [7:0]                         rx_data,
    output logic                               cmd_vld,
    input  logic                               cmd_rdy,
    output logic [7:0]                         cmd_id,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   cmd_len,
    output logic [8*MAX_PAYLOAD-1:0]           cmd_payload,
    output logic                               tx_vld,
    input  logic                               tx_rdy,
    output logic [7:0]                         tx_data,
    output logic                               err_len,
    output logic                               err_checksum,
    output logic                               err_timeout,
    output logic                               err_overrun
);

    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        IDLE,
        GET_ID,
        GET_LEN,
        GET_PAYLOAD,
        GET_CHK,
        DELIVER,
        RESPOND
    } state_t;

    state_t                   state_q;
    logic [7:0]               sum_q;
    logic [7:0]               sum_d;
    logic [LEN_W-1:0]         idx_q;
    logic [LEN_W-1:0]         idx_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     cmd_vld_q;
    logic [7:0]               cmd_id_q;
    logic [LEN_W-1:0]         cmd_len_q;
    logic [8*MAX_PAYLOAD-1:0] payload_q;
    logic                     tx_vld_q;
    logic [7:0]               tx_data_q;
    logic                     err_len_q;
    logic                     err_checksum_q;
    logic                     err_timeout_q;
    logic                     err_overrun_q;

    always_comb begin
        sum_d = sum_q + rx_data;
        idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            sum_q          <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            cmd_vld_q      <= 1'b0;
            cmd_id_q       <= '0;
            cmd_len_q      <= '0;
            payload_q      <= '0;
            tx_vld_q       <= 1'b0;
            tx_data_q      <= '0;
            err_len_q      <= 1'b0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            err_len_q      <= 1'b0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid && rx_data == SOF_BYTE) begin
                        state_q   <= GET_ID;
                        payload_q <= '0;
                        sum_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                GET_ID, GET_LEN, GET_PAYLOAD, GET_CHK: begin
                    // An arriving byte always beats a timeout expiring on the same cycle.
                    if (rx_valid) begin
                        cnt_q <= '0;
                        case (state_q)
                            GET_ID: begin
                                cmd_id_q <= rx_data;
                                sum_q    <= sum_d;
                                state_q  <= GET_LEN;
                            end
                            GET_LEN: begin
                                if (rx_data > 8'(MAX_PAYLOAD)) begin
                                    err_len_q <= 1'b1;
                                    tx_data_q <= NAK_BYTE;
                                    tx_vld_q  <= 1'b1;
                                    state_q   <= RESPOND;
                                end else begin
                                    cmd_len_q <= rx_data[LEN_W-1:0];
                                    sum_q     <= sum_d;
                                    idx_q     <= '0;
                                    state_q   <= (rx_data == 8'd0) ? GET_CHK : GET_PAYLOAD;
                                end
                            end
                            GET_PAYLOAD: begin
                                for (int k = 0; k < MAX_PAYLOAD; k++) begin
                                    if (idx_q == LEN_W'(k)) begin
                                        payload_q[8*k +: 8] <= rx_data;
                                    end
                                end
                                sum_q <= sum_d;
                                idx_q <= idx_d;
                                if (idx_d == cmd_len_q) begin
                                    state_q <= GET_CHK;
                                end
                            end
                            default: begin
                                if (rx_data == sum_q) begin
                                    cmd_vld_q <= 1'b1;
                                    state_q   <= DELIVER;
                                end else begin
                                    err_checksum_q <= 1'b1;
                                    tx_data_q      <= NAK_BYTE;
                                    tx_vld_q       <= 1'b1;
                                    state_q        <= RESPOND;
                                end
                            end
                        endcase
                    end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                        err_timeout_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DELIVER: begin
                    if (rx_valid) begin
                        err_overrun_q <= 1'b1;
                    end
                    if (cmd_rdy) begin
                        cmd_vld_q <= 1'b0;
                        tx_data_q <= ACK_BYTE;
                        tx_vld_q  <= 1'b1;
                        state_q   <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rx_valid) begin
                        err_overrun_q <= 1'b1;
                    end
                    if (tx_rdy) begin
                        tx_vld_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_vld      = cmd_vld_q;
    assign cmd_id       = cmd_id_q;
    assign cmd_len      = cmd_len_q;
    assign cmd_payload  = payload_q;
    assign tx_vld       = tx_vld_q;
    assign tx_data      = tx_data_q;
    assign err_len      = err_len_q;
    assign err_checksum = err_checksum_q;
    assign err_timeout  = err_timeout_q;
    assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus randomized frames
// compared against a frame-level reference model (checksum as plain arithmetic sum).
module tb_uart_cmd_parser;

    localparam int MAXP = 4;
    localparam int TOUT = 40;

    typedef logic [7:0] byteQ_t[$];

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [7:0]  cmd_id;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_payload;
    logic        tx_vld;
    logic        tx_rdy;
    logic [7:0]  tx_data;
    logic        err_len;
    logic        err_checksum;
    logic        err_timeout;
    logic        err_overrun;

    int testsRun;
    int testsFailed;

    uart_cmd_parser #(
        .MAX_PAYLOAD (MAXP),
        .TIMEOUT_CLKS(TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .cmd_vld     (cmd_vld),
        .cmd_rdy     (cmd_rdy),
        .cmd_id      (cmd_id),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy),
        .tx_data     (tx_data),
        .err_len     (err_len),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference checksum: ID + LEN + every payload byte, modulo 256.
    function automatic logic [7:0] modelChecksum(input logic [7:0] id, input logic [7:0] len, input byteQ_t pl);
        int s;
        s = int'(id) + int'(len);
        foreach (pl[i]) s += int'(pl[i]);
        return 8'(s % 256);
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic test_reset;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cmd_rdy = 1'b1; tx_rdy = 1'b1;
        idleCycles(3);
        testsRun++; if (cmd_vld !== 1'b0 || tx_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_vld: got cmd_vld=%b tx_vld=%b want 0 0", cmd_vld, tx_vld); end
        testsRun++; if ({err_len, err_checksum, err_timeout, err_overrun} !== 4'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b want 0000", {err_len, err_checksum, err_timeout, err_overrun}); end
        testsRun++; if (cmd_id !== 8'h0 || cmd_len !== 3'h0 || cmd_payload !== 32'h0 || tx_data !== 8'h0) begin testsFailed++; $display("[TB] FAIL reset_data: got id=%h len=%h pl=%h tx=%h want all 0", cmd_id, cmd_len, cmd_payload, tx_data); end
        reset = 1'b1;
        idleCycles(2);
    endtask

    task automatic test_valid_frame;
        cmd_rdy = 1'b1; tx_rdy = 1'b1;
        sendByte(8'hA5); sendByte(8'h10); sendByte(8'h02); sendByte(8'h34); sendByte(8'h12); sendByte(8'h58);
        testsRun++; if (cmd_vld !== 1'b1 || tx_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL valid_cmd_vld: got cmd_vld=%b tx_vld=%b want 1 0", cmd_vld, tx_vld); end
        testsRun++; if (cmd_id !== 8'h10 || cmd_len !== 3'd2 || cmd_payload !== 32'h0000_1234) begin testsFailed++; $display("[TB] FAIL valid_fields: got id=%h len=%0d pl=%h want 10 2 00001234", cmd_id, cmd_len, cmd_payload); end
        idleCycles(1);
        testsRun++; if (cmd_vld !== 1'b0 || tx_vld !== 1'b1 || tx_data !== 8'h06) begin testsFailed++; $display("[TB] FAIL valid_ack: got cmd_vld=%b tx_vld=%b tx=%h want 0 1 06", cmd_vld, tx_vld, tx_data); end
        idleCycles(1);
        testsRun++; if (tx_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL valid_ack_done: got tx_vld=%b want 0", tx_vld); end
    endtask

    task automatic test_bad_checksum;
        cmd_rdy = 1'b1; tx_rdy = 1'b1;
        sendByte(8'hA5); sendByte(8'h10); sendByte(8'h02); sendByte(8'h34); sendByte(8'h12); sendByte(8'h59);
        testsRun++; if (err_checksum !== 1'b1 || cmd_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL badchk_err: got err=%b cmd_vld=%b want 1 0", err_checksum, cmd_vld); end
        testsRun++; if (tx_vld !== 1'b1 || tx_data !== 8'h15) begin testsFailed++; $display("[TB] FAIL badchk_nak: got tx_vld=%b tx=%h want 1 15", tx_vld, tx_data); end
        idleCycles(1);
        testsRun++; if (err_checksum !== 1'b0 || tx_vld !== 1'b0 || cmd_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL badchk_after: got err=%b tx_vld=%b cmd_vld=%b want 0 0 0", err_checksum, tx_vld, cmd_vld); end
    endtask

    task automatic test_len_error;
        cmd_rdy = 1'b1; tx_rdy = 1'b1;
        sendByte(8'hA5); sendByte(8'h20); sendByte(8'h05);
        testsRun++; if (err_len !== 1'b1 || tx_vld !== 1'b1 || tx_data !== 8'h15) begin testsFailed++; $display("[TB] FAIL len_nak: got err=%b tx_vld=%b tx=%h want 1 1 15", err_len, tx_vld, tx_data); end
        idleCycles(1);
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h06);
        idleCycles(2);
        testsRun++; if ({cmd_vld, tx_vld, err_len, err_checksum, err_timeout, err_overrun} !== 6'b0) begin testsFailed++; $display("[TB] FAIL len_ignore: got %b want 000000", {cmd_vld, tx_vld, err_len, err_checksum, err_timeout, err_overrun}); end
    endtask

    task automatic test_zero_len;
        cmd_rdy = 1'b1; tx_rdy = 1'b1;
        sendByte(8'h00); sendByte(8'hFF); sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00); sendByte(8'h01);
        testsRun++; if (cmd_vld !== 1'b1 || cmd_id !== 8'h01 || cmd_len !== 3'd0 || cmd_payload !== 32'h0) begin testsFailed++; $display("[TB] FAIL zerolen_cmd: got vld=%b id=%h len=%0d pl=%h want 1 01 0 0", cmd_vld, cmd_id, cmd_len, cmd_payload); end
        idleCycles(1);
        testsRun++; if (tx_vld !== 1'b1 || tx_data !== 8'h06) begin testsFailed++; $display("[TB] FAIL zerolen_ack: got tx_vld=%b tx=%h want 1 06", tx_vld, tx_data); end
        idleCycles(1);
    endtask

    task automatic test_timeout;
        cmd_rdy = 1'b1; tx_rdy = 1'b1;
        // A byte landing on the expiry cycle must keep the frame alive.
        sendByte(8'hA5); sendByte(8'h10); idleCycles(TOUT - 1); sendByte(8'h00);
        testsRun++; if (err_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_bytewins_len: got err=%b want 0", err_timeout); end
        idleCycles(TOUT - 1); sendByte(8'h10);
        testsRun++; if (err_timeout !== 1'b0 || cmd_vld !== 1'b1 || cmd_id !== 8'h10) begin testsFailed++; $display("[TB] FAIL timeout_bytewins_chk: got err=%b vld=%b id=%h want 0 1 10", err_timeout, cmd_vld, cmd_id); end
        idleCycles(2);
        sendByte(8'hA5); sendByte(8'h10);
        idleCycles(TOUT - 1);
        testsRun++; if (err_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_early: got err=%b want 0", err_timeout); end
        idleCycles(1);
        testsRun++; if (err_timeout !== 1'b1 || tx_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_pulse: got err=%b tx_vld=%b want 1 0", err_timeout, tx_vld); end
        idleCycles(1);
        testsRun++; if (err_timeout !== 1'b0 || tx_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_after: got err=%b tx_vld=%b want 0 0", err_timeout, tx_vld); end
        sendByte(8'hA5); sendByte(8'h22); sendByte(8'h01); sendByte(8'h7E); sendByte(8'hA1);
        testsRun++; if (cmd_vld !== 1'b1 || cmd_id !== 8'h22 || cmd_len !== 3'd1 || cmd_payload !== 32'h0000_007E) begin testsFailed++; $display("[TB] FAIL timeout_recover: got vld=%b id=%h len=%0d pl=%h want 1 22 1 0000007e", cmd_vld, cmd_id, cmd_len, cmd_payload); end
        idleCycles(2);
    endtask

    task automatic test_backpressure;
        cmd_rdy = 1'b0; tx_rdy = 1'b0;
        sendByte(8'hA5); sendByte(8'h33); sendByte(8'h03); sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h3C);
        idleCycles(50);
        sendByte(8'h77);
        testsRun++; if (err_overrun !== 1'b1 || cmd_vld !== 1'b1 || cmd_id !== 8'h33 || cmd_len !== 3'd3 || cmd_payload !== 32'h0003_0201) begin testsFailed++; $display("[TB] FAIL bp_overrun_cmd: got ovr=%b vld=%b id=%h len=%0d pl=%h want 1 1 33 3 00030201", err_overrun, cmd_vld, cmd_id, cmd_len, cmd_payload); end
        idleCycles(49);
        testsRun++; if (err_overrun !== 1'b0 || cmd_vld !== 1'b1 || tx_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_hold_cmd: got ovr=%b vld=%b tx_vld=%b want 0 1 0", err_overrun, cmd_vld, tx_vld); end
        cmd_rdy = 1'b1;
        idleCycles(1);
        cmd_rdy = 1'b0;
        testsRun++; if (cmd_vld !== 1'b0 || tx_vld !== 1'b1 || tx_data !== 8'h06) begin testsFailed++; $display("[TB] FAIL bp_ack_rise: got vld=%b tx_vld=%b tx=%h want 0 1 06", cmd_vld, tx_vld, tx_data); end
        idleCycles(25);
        sendByte(8'h77);
        testsRun++; if (err_overrun !== 1'b1 || tx_vld !== 1'b1 || tx_data !== 8'h06) begin testsFailed++; $display("[TB] FAIL bp_overrun_tx: got ovr=%b tx_vld=%b tx=%h want 1 1 06", err_overrun, tx_vld, tx_data); end
        idleCycles(24);
        testsRun++; if (tx_vld !== 1'b1 || tx_data !== 8'h06) begin testsFailed++; $display("[TB] FAIL bp_hold_tx: got tx_vld=%b tx=%h want 1 06", tx_vld, tx_data); end
        tx_rdy = 1'b1;
        idleCycles(1);
        testsRun++; if (tx_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_tx_done: got tx_vld=%b want 0", tx_vld); end
    endtask

    task automatic test_reset_midframe;
        cmd_rdy = 1'b1; tx_rdy = 1'b1;
        sendByte(8'hA5); sendByte(8'h44); sendByte(8'h02); sendByte(8'hAA);
        reset = 1'b0;
        #1;
        testsRun++; if ({cmd_vld, tx_vld, err_len, err_checksum, err_timeout, err_overrun} !== 6'b0 || cmd_id !== 8'h0 || cmd_len !== 3'd0 || cmd_payload !== 32'h0 || tx_data !== 8'h0) begin testsFailed++; $display("[TB] FAIL rst_mid_outputs: got flags=%b id=%h len=%0d pl=%h tx=%h want all 0", {cmd_vld, tx_vld, err_len, err_checksum, err_timeout, err_overrun}, cmd_id, cmd_len, cmd_payload, tx_data); end
        reset = 1'b1;
        idleCycles(1);
        sendByte(8'hBB);
        idleCycles(1);
        testsRun++; if (cmd_vld !== 1'b0 || tx_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_quiet: got vld=%b tx_vld=%b want 0 0", cmd_vld, tx_vld); end
        sendByte(8'hA5); sendByte(8'h55); sendByte(8'h00); sendByte(8'h55);
        testsRun++; if (cmd_vld !== 1'b1 || cmd_id !== 8'h55 || cmd_len !== 3'd0) begin testsFailed++; $display("[TB] FAIL rst_mid_next: got vld=%b id=%h len=%0d want 1 55 0", cmd_vld, cmd_id, cmd_len); end
        idleCycles(2);
    endtask

    task automatic test_random(input int n);
        int         kind;
        int         dly;
        logic [7:0] id;
        logic [7:0] len;
        logic [7:0] chk;
        logic [7:0] g;
        logic [31:0] expPayload;
        byteQ_t     pl;
        for (int f = 0; f < n; f++) begin
            kind = $urandom_range(0, 8);
            id   = 8'($urandom);
            len  = (kind == 8) ? 8'($urandom_range(MAXP + 1, 255)) : 8'($urandom_range(0, MAXP));
            pl.delete();
            expPayload = '0;
            for (int i = 0; i < int'(len) && i < MAXP; i++) begin
                pl.push_back(8'($urandom));
                expPayload[8*i +: 8] = pl[i];
            end
            chk = modelChecksum(id, len, pl);
            if (kind == 6 || kind == 7) chk = chk ^ 8'($urandom_range(1, 255));
            cmd_rdy = 1'b0; tx_rdy = 1'b0;
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                sendByte(g);
            end
            sendByte(8'hA5);
            idleCycles($urandom_range(0, 3)); sendByte(id);
            idleCycles($urandom_range(0, 3)); sendByte(len);
            if (kind == 8) begin
                testsRun++; if (err_len !== 1'b1 || tx_vld !== 1'b1 || tx_data !== 8'h15) begin testsFailed++; $display("[TB] FAIL rnd_len[%0d]: got err=%b tx_vld=%b tx=%h want 1 1 15", f, err_len, tx_vld, tx_data); end
            end else begin
                foreach (pl[i]) begin
                    idleCycles($urandom_range(0, 3)); sendByte(pl[i]);
                end
                idleCycles($urandom_range(0, 3)); sendByte(chk);
                if (kind <= 5) begin
                    testsRun++; if (cmd_vld !== 1'b1 || cmd_id !== id || cmd_len !== len[2:0] || cmd_payload !== expPayload) begin testsFailed++; $display("[TB] FAIL rnd_cmd[%0d]: got vld=%b id=%h len=%0d pl=%h want 1 %h %0d %h", f, cmd_vld, cmd_id, cmd_len, cmd_payload, id, len, expPayload); end
                    dly = $urandom_range(0, 5);
                    idleCycles(dly);
                    testsRun++; if (cmd_vld !== 1'b1 || cmd_payload !== expPayload) begin testsFailed++; $display("[TB] FAIL rnd_hold[%0d]: got vld=%b pl=%h want 1 %h", f, cmd_vld, cmd_payload, expPayload); end
                    cmd_rdy = 1'b1;
                    idleCycles(1);
                    cmd_rdy = 1'b0;
                    testsRun++; if (cmd_vld !== 1'b0 || tx_vld !== 1'b1 || tx_data !== 8'h06) begin testsFailed++; $display("[TB] FAIL rnd_ack[%0d]: got vld=%b tx_vld=%b tx=%h want 0 1 06", f, cmd_vld, tx_vld, tx_data); end
                end else begin
                    testsRun++; if (err_checksum !== 1'b1 || cmd_vld !== 1'b0 || tx_vld !== 1'b1 || tx_data !== 8'h15) begin testsFailed++; $display("[TB] FAIL rnd_chk[%0d]: got err=%b vld=%b tx_vld=%b tx=%h want 1 0 1 15", f, err_checksum, cmd_vld, tx_vld, tx_data); end
                end
            end
            idleCycles($urandom_range(0, 4));
            tx_rdy = 1'b1;
            idleCycles(1);
            tx_rdy = 1'b0;
            testsRun++; if (tx_vld !== 1'b0 || cmd_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL rnd_done[%0d]: got tx_vld=%b vld=%b want 0 0", f, tx_vld, cmd_vld); end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_len_error();
        test_zero_len();
        test_timeout();
        test_backpressure();
        test_reset_midframe();
        test_random(40);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame-level command parser sitting directly downstream of the byte UART receiver and upstream of its transmitter. Consumes single-cycle `rx_valid`/`rx_data` byte pulses and assembles framed commands. Validates length and checksum, then hands complete commands to rover control logic over a valid/ready port. Returns a one-byte ACK or NAK to the host through the UART TX valid/ready port.

## Interface
- `MAX_PAYLOAD`, 4: maximum payload bytes per frame (1..15).
- `SOF_BYTE`, 8'hA5: start-of-frame marker.
- `ACK_BYTE`, 8'h06: response sent after a command is accepted downstream.
- `NAK_BYTE`, 8'h15: response sent on a length or checksum error.
- `TIMEOUT_CLKS`, 480000: max idle clocks between bytes inside a frame (10 ms at 48 MHz).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `rx_data`  in  8  received byte, valid with `rx_valid`.
- `cmd_vld`  out  1  command available.
- `cmd_rdy`  in  1  consumer accepts the command.
- `cmd_id`  out  8  command identifier.
- `cmd_len`  out  $clog2(MAX_PAYLOAD+1)  payload byte count.
- `cmd_payload`  out  8*MAX_PAYLOAD  payload; byte k in bits [8k+7:8k].
- `tx_vld`  out  1  response byte valid.
- `tx_rdy`  in  1  UART TX idle/ready.
- `tx_data`  out  8  response byte.
- `err_len`  out  1  one-cycle pulse: LEN > MAX_PAYLOAD.
- `err_checksum`  out  1  one-cycle pulse: checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse: inter-byte timeout.
- `err_overrun`  out  1  one-cycle pulse: byte dropped while busy.

## Operation
- Frame format: SOF, ID, LEN, PAYLOAD[0..LEN-1], CHK.
- CHK = (ID + LEN + sum of payload bytes) mod 256. SOF is excluded from CHK.
- FSM states and transitions:
  - IDLE: on a byte equal to SOF → GET_ID, clear `cmd_payload` to 0 and the running sum to 0. Any other byte is discarded silently.
  - GET_ID → GET_LEN.
  - GET_LEN:
    - LEN > MAX_PAYLOAD → pulse `err_len`, go to RESPOND with NAK.
    - LEN = 0 → GET_CHK.
    - Otherwise → GET_PAYLOAD.
  - GET_PAYLOAD: store each byte at index 0..LEN-1; after byte LEN-1 → GET_CHK.
  - GET_CHK:
    - Match → DELIVER.
    - Mismatch → pulse `err_checksum`, go to RESPOND with NAK.
  - DELIVER: hold `cmd_vld`=1. On `cmd_vld && cmd_rdy` → RESPOND with ACK.
  - RESPOND: hold `tx_vld`=1 with `tx_data` fixed. On `tx_vld && tx_rdy` → IDLE.
- Timeout counter:
  - Active only in GET_ID, GET_LEN, GET_PAYLOAD and GET_CHK.
  - Cleared on SOF and on every byte accepted in those states.
  - Reaching TIMEOUT_CLKS-1 with no byte → pulse `err_timeout`, go to IDLE, send no response.
- Overrun: a byte arriving in DELIVER or RESPOND is dropped and pulses `err_overrun`. State and outputs are unchanged.
- Arithmetic: running sum is 8-bit and wraps. Timeout counter width is $clog2(TIMEOUT_CLKS).

## Timing
- Reset values: `cmd_vld`, `tx_vld`, all `err_*` = 0; `cmd_id`, `cmd_len`, `cmd_payload`, `tx_data` = 0. FSM = IDLE.
- All outputs are registered. The FSM processes at most one byte per cycle.
- `cmd_vld` rises 1 cycle after the CHK byte's `rx_valid`. `cmd_id`, `cmd_len` and `cmd_payload` are stable while `cmd_vld`=1.
- `cmd_vld` falls the cycle after the handshake. ACK `tx_vld` rises on that same cycle.
- NAK `tx_vld` rises 1 cycle after the offending LEN or CHK byte.
- `tx_vld` is held regardless of `tx_rdy` and deasserts the cycle after `tx_vld && tx_rdy`.
- Error pulses are exactly 1 cycle wide, coincident with the state change they cause.
- Simultaneous events:
  - Byte arrival and timeout expiry on the same cycle → the byte wins and the counter clears.
  - A SOF byte mid-frame is treated as data, not as a resync.
- Reset asserted mid-frame or mid-handshake → immediate return to reset values. Any partial frame is discarded and no response is sent.
- Minimum frame-to-ACK latency with `cmd_rdy`=`tx_rdy`=1: `tx_vld` rises 2 cycles after the CHK byte.

## Test plan
- Valid frame A5 10 02 34 12 58, `cmd_rdy`=`tx_rdy`=1:
  - `cmd_vld` 1 cycle with `cmd_id`=10, `cmd_len`=2, `cmd_payload`[15:0]=16'h1234, upper bits 0.
  - Then `tx_data`=06 with one `tx_vld` handshake.
- Bad checksum A5 10 02 34 12 59 → `err_checksum` pulse, `cmd_vld` never asserts, `tx_data`=15 sent.
- Length error A5 20 05 with MAX_PAYLOAD=4:
  - `err_len` pulse and NAK 15 after the LEN byte.
  - Following bytes are ignored until the next A5.
- Garbage then zero-length frame 00 FF A5 01 00 01 → `cmd_id`=01, `cmd_len`=0, `cmd_payload`=0, then ACK 06.
- Timeout, then recovery:
  - A5 10, then silence for TIMEOUT_CLKS → `err_timeout` pulse, no `tx_vld`.
  - The next valid frame is parsed correctly.
- Backpressure:
  - Hold `cmd_rdy`=0 for 100 cycles and inject byte 77 → `err_overrun` pulse, command fields unchanged.
  - Then hold `tx_rdy`=0 for 50 cycles → `tx_vld` stays high with `tx_data`=06 until `tx_rdy`.
  - Assert `reset` mid-frame → all outputs 0, and the next frame parses cleanly.
